sumcheck_verifier_round: RTL and testbench

SUMCHECK_VERIFIER_ROUND -- requirements
Module: sumcheck_verifier_round

---
 rtl/sumcheck_verifier_round.sv | 217 +++++++++++++++++++++
 tb/tb_sumcheck_verifier_round.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumcheck_verifier_round.sv
// Sumcheck verifier for a layered proof over the Mersenne field p = 2^61-1.
// Each round takes one degree-2 prover message {f2, f1, f0}, checks f0+f1
// against the running claim, issues an LFSR challenge r, and folds the
// claim to f(r) through a 5-cycle evaluation that shares one multiplier.
// Optional feature macro: SUMCHECK_TYPE_CHECK_EN rejects any message whose
// msg_type differs from CMT_F012. Without it, msg_type is ignored.
module sumcheck_verifier_round #(
    parameter int          NROUNDS = 8,
    parameter int          NLAYERS = 3,
    parameter logic [60:0] SEED    = 61'h1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [60:0]  claim_in,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [2:0]   msg_type,
    input  logic [182:0] msg_data,
    output logic         chal_valid,
    input  logic         chal_ready,
    output logic [60:0]  chal_data,
    output logic [7:0]   layer,
    output logic [7:0]   round,
    output logic         done,
    output logic         accept,
    output logic         reject
);

    localparam logic [60:0] P          = {61{1'b1}};
    localparam logic [60:0] INV2       = 61'h1000000000000000;  // 2^60 = 1/2 mod p
    localparam logic [2:0]  CMT_F012   = 3'd1;
    localparam logic [7:0]  LAST_ROUND = 8'(NROUNDS - 1);
    localparam logic [7:0]  LAST_LAYER = 8'(NLAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_F, S_CHECK, S_CHAL, S_EVAL, S_FIN
    } state_t;

    state_t       r_state, w_state_next;
    logic [60:0]  r_claim, r_f0, r_f1, r_f2;
    logic [60:0]  r_lfsr, r_chal;
    logic [60:0]  r_a, r_b, r_c;
    logic [2:0]   r_cyc;
    logic [7:0]   r_layer, r_round;
    logic         r_done, r_accept, r_reject;

    logic [60:0]  w_r, w_lfsr_next, w_d1, w_d2, w_r_m1;
    logic [60:0]  w_op_a, w_op_b, w_prod, w_claim_next;
    logic         w_check_ok, w_type_ok, w_last_eval, w_all_done;

    // The value p is an alias of 0 on every operand.
    function automatic logic [60:0] f_norm(input logic [60:0] x);
        return (x == P) ? 61'd0 : x;
    endfunction

    // Fold a value below 2^62-1 into [0, p-1].
    function automatic logic [60:0] f_fold(input logic [61:0] s);
        logic [60:0] t;
        t = s[60:0] + 61'(s[61]);
        return f_norm(t);
    endfunction

    function automatic logic [60:0] f_add(input logic [60:0] a, input logic [60:0] b);
        return f_fold({1'b0, f_norm(a)} + {1'b0, f_norm(b)});
    endfunction

    // 2^61 == 1 mod p, so the high half of the product adds onto the low half.
    function automatic logic [60:0] f_mul(input logic [60:0] a, input logic [60:0] b);
        logic [121:0] pr;
        pr = {61'd0, f_norm(a)} * {61'd0, f_norm(b)};
        return f_fold({1'b0, pr[60:0]} + {1'b0, pr[121:61]});
    endfunction

    // Subtraction uses ~y == p - y; ~0 == p, which the adder treats as 0.
    assign w_r_m1      = f_add(r_chal, ~61'd1);
    assign w_d1        = f_add(r_f1, ~r_f0);
    assign w_d2        = f_add(f_add(r_f2, r_f0), ~f_add(r_f1, r_f1));
    assign w_r         = (r_lfsr == P) ? 61'd0 : r_lfsr;
    assign w_lfsr_next = {r_lfsr[59:0], r_lfsr[60] ^ r_lfsr[4] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_check_ok  = (f_add(r_f0, r_f1) == r_claim);
    assign w_last_eval = (r_state == S_EVAL) && (r_cyc == 3'd4);
    assign w_all_done  = (r_round == LAST_ROUND) && (r_layer == LAST_LAYER);
    assign w_prod      = f_mul(w_op_a, w_op_b);
    assign w_claim_next = f_add(f_add(r_f0, r_a), r_b);

`ifdef SUMCHECK_TYPE_CHECK_EN
    assign w_type_ok = (msg_type == CMT_F012);
`else
    logic w_unused_type;
    assign w_unused_type = ^msg_type;
    assign w_type_ok     = 1'b1;
`endif

    // Operand select for the single shared multiplier across EVAL steps.
    always_comb begin
        w_op_a = r_b;
        w_op_b = r_c;
        case (r_cyc)
            3'd0:    begin w_op_a = r_chal; w_op_b = w_d1;   end
            3'd1:    begin w_op_a = r_chal; w_op_b = w_r_m1; end
            3'd2:    begin w_op_a = w_d2;   w_op_b = INV2;   end
            default: begin w_op_a = r_b;    w_op_b = r_c;    end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start)      w_state_next = S_WAIT_F;
            S_WAIT_F: if (msg_valid)  w_state_next = w_type_ok ? S_CHECK : S_FIN;
            S_CHECK:                  w_state_next = w_check_ok ? S_CHAL : S_FIN;
            S_CHAL:   if (chal_ready) w_state_next = S_EVAL;
            S_EVAL:   if (w_last_eval) w_state_next = w_all_done ? S_FIN : S_WAIT_F;
            S_FIN:                    w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // Datapath: claim, message, challenge, LFSR, evaluation and verdict registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_claim  <= '0;
            r_f0     <= '0;
            r_f1     <= '0;
            r_f2     <= '0;
            r_lfsr   <= SEED;
            r_chal   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_cyc    <= '0;
            r_layer  <= '0;
            r_round  <= '0;
            r_done   <= 1'b0;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_claim  <= f_norm(claim_in);
                        r_layer  <= '0;
                        r_round  <= '0;
                        r_done   <= 1'b0;
                        r_accept <= 1'b0;
                        r_reject <= 1'b0;
                    end
                end
                S_WAIT_F: begin
                    if (msg_valid) begin
                        r_f0 <= f_norm(msg_data[60:0]);
                        r_f1 <= f_norm(msg_data[121:61]);
                        r_f2 <= f_norm(msg_data[182:122]);
                        if (!w_type_ok) begin
                            r_reject <= 1'b1;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_check_ok) begin
                        r_chal <= w_r;
                    end else begin
                        r_reject <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                S_CHAL: begin
                    if (chal_ready) begin
                        r_lfsr <= w_lfsr_next;
                        r_cyc  <= '0;
                    end
                end
                S_EVAL: begin
                    r_cyc <= r_cyc + 3'd1;
                    case (r_cyc)
                        3'd0: r_a <= w_prod;
                        3'd1: r_b <= w_prod;
                        3'd2: r_c <= w_prod;
                        3'd3: r_b <= w_prod;
                        default: begin
                            r_claim <= w_claim_next;
                            if (r_round != LAST_ROUND) begin
                                r_round <= r_round + 8'd1;
                            end else if (r_layer != LAST_LAYER) begin
                                r_round <= '0;
                                r_layer <= r_layer + 8'd1;
                            end else begin
                                r_accept <= 1'b1;
                                r_done   <= 1'b1;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign msg_ready  = (r_state == S_WAIT_F);
    assign chal_valid = (r_state == S_CHAL);
    assign chal_data  = r_chal;
    assign layer      = r_layer;
    assign round      = r_round;
    assign done       = r_done;
    assign accept     = r_accept;
    assign reject     = r_reject;

endmodule

// File: tb/tb_sumcheck_verifier_round.sv
// Testbench for sumcheck_verifier_round (NROUNDS=2, NLAYERS=2, SEED=0x10).
// Vector table drives first-round messages; later rounds use consistent
// random messages whose claims come from a Lagrange-form reference model.
module tb_sumcheck_verifier_round;

    localparam int          NR   = 2;
    localparam int          NL   = 2;
    localparam logic [60:0] SEED = 61'h10;
    localparam logic [60:0] P    = {61{1'b1}};
    localparam logic [60:0] INV2 = 61'h1000000000000000;
    localparam logic [127:0] PW  = {67'd0, {61{1'b1}}};

    logic         clk, rstn, start, msg_valid, msg_ready, chal_valid, chal_ready;
    logic         done, accept, reject;
    logic [60:0]  claim_in, chal_data;
    logic [2:0]   msg_type;
    logic [182:0] msg_data;
    logic [7:0]   layer, round;

    sumcheck_verifier_round #(.NROUNDS(NR), .NLAYERS(NL), .SEED(SEED)) dut (
        .clk(clk), .rstn(rstn), .start(start), .claim_in(claim_in),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
        .msg_data(msg_data), .chal_valid(chal_valid), .chal_ready(chal_ready),
        .chal_data(chal_data), .layer(layer), .round(round),
        .done(done), .accept(accept), .reject(reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [60:0] m_lfsr, m_claim;
    logic [60:0] exp_q[$];

    typedef struct {
        logic [60:0] claim_in;
        logic [60:0] f0, f1, f2;
        bit          exp_pass;
        int          hold;
    } vec_t;
    vec_t vecs[6];

    // ---------------- reference model ----------------
    function automatic logic [60:0] fm(input logic [127:0] x);
        logic [127:0] t;
        t = x % PW;
        return t[60:0];
    endfunction
    function automatic logic [60:0] m_add(input logic [60:0] a, input logic [60:0] b);
        return fm({67'd0, a} + {67'd0, b});
    endfunction
    function automatic logic [60:0] m_sub(input logic [60:0] a, input logic [60:0] b);
        return fm({67'd0, a} + PW - {67'd0, fm({67'd0, b})});
    endfunction
    function automatic logic [60:0] m_mul(input logic [60:0] a, input logic [60:0] b);
        return fm({67'd0, a} * {67'd0, b});
    endfunction
    // f(r) = f0*(r-1)(r-2)/2 - f1*r(r-2) + f2*r(r-1)/2
    function automatic logic [60:0] interp(input logic [60:0] f0, input logic [60:0] f1,
                                           input logic [60:0] f2, input logic [60:0] r);
        logic [60:0] rm1, rm2, t0, t1, t2;
        rm1 = m_sub(r, 61'd1);
        rm2 = m_sub(r, 61'd2);
        t0  = m_mul(m_mul(rm1, rm2), INV2);
        t1  = m_mul(r, rm2);
        t2  = m_mul(m_mul(r, rm1), INV2);
        return m_sub(m_add(m_mul(f0, t0), m_mul(f2, t2)), m_mul(f1, t1));
    endfunction
    function automatic logic [60:0] lfsr_next(input logic [60:0] s);
        return {s[59:0], s[60] ^ s[4] ^ s[1] ^ s[0]};
    endfunction
    function automatic logic [60:0] r_of(input logic [60:0] s);
        return (s == P) ? 61'd0 : s;
    endfunction
    function automatic logic [60:0] rnd61();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return fm({64'd0, x});
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // accept and reject must never coexist
    always @(negedge clk) begin
        if (rstn && accept && reject) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_reject_excl: accept=%0b reject=%0b, expected not both", accept, reject);
        end
    end

    task automatic do_start(input logic [60:0] c);
        claim_in = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Returns at the negedge right after the handshake edge (DUT in CHECK).
    task automatic send_msg(input logic [60:0] f0, input logic [60:0] f1, input logic [60:0] f2);
        int w;
        w = 0;
        while (!msg_ready && w < 20) begin
            tick();
            w++;
        end
        chk("msg_ready_wait", msg_ready, 1);
        $display("msg  L%0d R%0d f0=%0h f1=%0h f2=%0h", layer, round, f0, f1, f2);
        msg_data  = {f2, f1, f0};
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
    endtask

    // Called at a negedge with the DUT in CHAL; holds ready low, then handshakes.
    task automatic chal_phase(input int hold, output logic [60:0] r);
        logic [60:0] ex;
        ex = '0;
        chk("chal_valid", chal_valid, 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL chal_scoreboard: got challenge 0x%0h, expected none queued", chal_data);
        end else begin
            ex = exp_q.pop_front();
            chk("chal_data", chal_data, ex);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("chal_hold_valid", chal_valid, 1);
            chk("chal_hold_data", chal_data, ex);
        end
        $display("chal r=%0h after %0d stall cycles", chal_data, hold);
        chal_ready = 1'b1;
        tick();
        chal_ready = 1'b0;
        r = ex;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [60:0] f0, f1, f2, r;
        bit          ok;
        $display("run  vec %0d claim_in=%0h", idx, v.claim_in);
        do_start(v.claim_in);
        m_claim = fm({67'd0, v.claim_in});
        chk("start_done_clr", done, 0);
        chk("start_acc_clr", accept, 0);
        chk("start_rej_clr", reject, 0);
        for (int L = 0; L < NL; L++) begin
            for (int R = 0; R < NR; R++) begin
                if (L == 0 && R == 0) begin
                    f0 = v.f0; f1 = v.f1; f2 = v.f2; ok = v.exp_pass;
                end else begin
                    f0 = rnd61(); f1 = m_sub(m_claim, f0); f2 = rnd61(); ok = 1'b1;
                end
                chk("layer", layer, 64'(L));
                chk("round", round, 64'(R));
                if (ok) exp_q.push_back(r_of(m_lfsr));
                send_msg(f0, f1, f2);
                tick();
                if (!ok) begin
                    chk("rej_reject", reject, 1);
                    chk("rej_done", done, 1);
                    chk("rej_accept", accept, 0);
                    chk("rej_no_chal", chal_valid, 0);
                    tick();
                    chk("rej_hold_reject", reject, 1);
                    chk("rej_hold_done", done, 1);
                    chk("rej_idle_no_chal", chal_valid, 0);
                    return;
                end
                chal_phase(v.hold, r);
                m_claim = interp(f0, f1, f2, r);
                m_lfsr  = lfsr_next(m_lfsr);
                repeat (4) tick();
                chk("eval_len_busy", msg_ready | done, 0);
                tick();
                if (!(L == NL - 1 && R == NR - 1)) chk("eval_len_ready", msg_ready, 1);
            end
        end
        chk("acc_accept", accept, 1);
        chk("acc_done", done, 1);
        chk("acc_reject", reject, 0);
        tick();
        tick();
        chk("acc_hold_idle", accept, 1);
        chk("acc_idle_no_ready", msg_ready, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_msg_ready"}, msg_ready, 0);
        chk({tag, "_chal_valid"}, chal_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_accept"}, accept, 0);
        chk({tag, "_reject"}, reject, 0);
        chk({tag, "_chal_data"}, chal_data, 0);
        chk({tag, "_layer"}, layer, 0);
        chk({tag, "_round"}, round, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [60:0] r;
        rstn = 1'b1; start = 1'b0; claim_in = '0; msg_valid = 1'b0;
        msg_type = 3'd1; msg_data = '0; chal_ready = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rstn = 1'b1;
        m_lfsr = SEED;
        tick();

        vecs[0] = '{claim_in: 61'd12, f0: 61'd5,   f1: 61'd7,   f2: 61'd9,    exp_pass: 1'b1, hold: 0};
        vecs[1] = '{claim_in: 61'd13, f0: 61'd5,   f1: 61'd7,   f2: 61'd9,    exp_pass: 1'b0, hold: 0};
        vecs[2] = '{claim_in: 61'd1,  f0: P - 1,   f1: 61'd2,   f2: 61'd3,    exp_pass: 1'b1, hold: 5};
        vecs[3] = '{claim_in: P,      f0: P,       f1: 61'd0,   f2: 61'd7,    exp_pass: 1'b1, hold: 1};
        vecs[4] = '{claim_in: 61'd0,  f0: 61'd1,   f1: P - 1,   f2: P - 2,    exp_pass: 1'b1, hold: 2};
        vecs[5] = '{claim_in: 61'd100, f0: 61'd50, f1: 61'd49,  f2: 61'd0,    exp_pass: 1'b0, hold: 0};

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // start while in WAIT_F must be ignored; then reset in the middle of EVAL
        $display("seq  start-ignored then reset at EVAL c2");
        do_start(61'd12);
        claim_in = 61'd99;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("ign_layer", layer, 0);
        chk("ign_round", round, 0);
        exp_q.push_back(r_of(m_lfsr));
        send_msg(61'd5, 61'd7, 61'd9);
        tick();
        chal_phase(0, r);
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk_reset_outputs("mid_eval");
        @(negedge clk);
        rstn = 1'b1;
        m_lfsr = SEED;
        exp_q.delete();
        tick();
        run_vec(vecs[0], 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
